alu_result_stage: RTL and testbench

- Pipeline register and flag generator directly downstream of the 32-bit ALU (and32 and its sibling logic units).
- Captures each ALU result with its destination register tag, derives zero/negative flags and carries the carry/overflow flags through.
- Buffers up to two results in a skid buffer with valid/ready handshakes on both sides, so writeback back-pressure never drops an ALU result.

---
 rtl/alu_result_stage.sv | 166 ++++++++++++++++
 tb/tb_alu_result_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: two-entry skid buffer between the ALU and writeback.
// Captures each ALU result with its destination tag, derives zero/negative
// flags at capture time and passes carry/overflow through. Outputs come
// straight from the head entry register; the head is kept cleared while
// the buffer is empty so out_* read as zero with no extra masking.
module alu_result_stage #(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_result,
  input  logic               in_carry,
  input  logic               in_ovf,
  input  logic [RD_BITS-1:0] in_rd,
  input  logic               in_we,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [RD_BITS-1:0] out_rd,
  output logic               out_we,
  output logic               out_zero,
  output logic               out_neg,
  output logic               out_carry,
  output logic               out_ovf
);

  typedef struct packed {
    logic [WIDTH-1:0]   result;
    logic [RD_BITS-1:0] rd;
    logic               we;
    logic               zero;
    logic               neg;
    logic               carry;
    logic               ovf;
  } entry_t;

  localparam entry_t EMPTY_ENTRY = {$bits(entry_t){1'b0}};

  // Build a buffer entry from the raw ALU outputs, deriving the flags.
  function automatic entry_t make_entry(
    input logic [WIDTH-1:0]   result,
    input logic [RD_BITS-1:0] rd,
    input logic               we,
    input logic               carry,
    input logic               ovf
  );
    entry_t e;
    e.result = result;
    e.rd     = rd;
    e.we     = we;
    e.zero   = (result == {WIDTH{1'b0}});
    e.neg    = result[WIDTH-1];
    e.carry  = carry;
    e.ovf    = ovf;
    return e;
  endfunction

  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic       not_full_s;
  logic       push_s;
  logic       pop_s;
  entry_t     new_entry_s;

  // Handshake terms come only from registered count, never from out_ready.
  // rst_n gates only the visible ready; the flops are already held in reset.
  always_comb begin
    not_full_s  = (count_q != 2'd2);
    in_ready    = rst_n & not_full_s;
    out_valid   = (count_q != 2'd0);
    push_s      = in_valid & not_full_s;
    pop_s       = out_valid & out_ready;
    new_entry_s = make_entry(in_result, in_rd, in_we, in_carry, in_ovf);
  end

  // Next-state for count and both entries; flush overrides push and pop.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      count_d = 2'd0;
      head_d  = EMPTY_ENTRY;
      tail_d  = EMPTY_ENTRY;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          case (count_q)
            2'd0: begin
              head_d  = new_entry_s;
              count_d = 2'd1;
            end
            2'd1: begin
              tail_d  = new_entry_s;
              count_d = 2'd2;
            end
            default: begin
              count_d = count_q;
            end
          endcase
        end
        2'b01: begin
          case (count_q)
            2'd1: begin
              head_d  = EMPTY_ENTRY;
              count_d = 2'd0;
            end
            2'd2: begin
              head_d  = tail_q;
              tail_d  = EMPTY_ENTRY;
              count_d = 2'd1;
            end
            default: begin
              count_d = count_q;
            end
          endcase
        end
        2'b11: begin
          // Only reachable at count 1: the new entry replaces the popped head.
          case (count_q)
            2'd1: begin
              head_d  = new_entry_s;
              count_d = 2'd1;
            end
            default: begin
              count_d = count_q;
            end
          endcase
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // State registers; asynchronous reset empties the buffer immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= EMPTY_ENTRY;
      tail_q  <= EMPTY_ENTRY;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Present the head entry register directly toward writeback.
  always_comb begin
    out_result = head_q.result;
    out_rd     = head_q.rd;
    out_we     = head_q.we;
    out_zero   = head_q.zero;
    out_neg    = head_q.neg;
    out_carry  = head_q.carry;
    out_ovf    = head_q.ovf;
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage with a queue-based reference model
// and a per-cycle compare process, plus hand-computed literal checks.
module tb_alu_result_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_carry;
  logic        in_ovf;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_zero;
  logic        out_neg;
  logic        out_carry;
  logic        out_ovf;

  int n_total = 0;
  int n_pass  = 0;

  alu_result_stage #(.WIDTH(32), .RD_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_carry(in_carry), .in_ovf(in_ovf), .in_rd(in_rd), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_we(out_we), .out_zero(out_zero), .out_neg(out_neg),
    .out_carry(out_carry), .out_ovf(out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: an ordered queue of pending results, capacity two.
  typedef struct {
    logic [31:0] r;
    logic [4:0]  rd;
    logic        we;
    logic        c;
    logic        o;
  } ent_t;

  ent_t mq[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      ent_t e;
      bit   do_push;
      do_push = in_valid && (mq.size() < 2);
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (do_push) begin
        e.r = in_result; e.rd = in_rd; e.we = in_we; e.c = in_carry; e.o = in_ovf;
        mq.push_back(e);
      end
    end
  end

  // Compare DUT against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    logic [41:0] exp_head;
    logic        exp_rdy;
    exp_rdy = rst_n && (mq.size() < 2);
    if (mq.size() > 0) begin
      exp_head = {mq[0].r, mq[0].rd, mq[0].we, (mq[0].r == 32'd0), mq[0].r[31], mq[0].c, mq[0].o};
    end else begin
      exp_head = 42'd0;
    end
    check("model_ready_valid", {62'd0, in_ready, out_valid}, {62'd0, exp_rdy, (mq.size() > 0)});
    check("model_head",
          {22'd0, out_result, out_rd, out_we, out_zero, out_neg, out_carry, out_ovf},
          {22'd0, exp_head});
  end

  // Apply one cycle of inputs, then return 1ns after the rising edge.
  task automatic drive(input logic v, input logic [31:0] r, input logic c, input logic o,
                       input logic [4:0] rd, input logic we, input logic ordy, input logic fl);
    in_valid  = v;
    in_result = r;
    in_carry  = c;
    in_ovf    = o;
    in_rd     = rd;
    in_we     = we;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_result = 32'd0;
    in_carry = 1'b0; in_ovf = 1'b0; in_rd = 5'd0; in_we = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd0);
    check("reset_out_result", {32'd0, out_result}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", {63'd0, in_ready}, 64'd1);

    // 1: zero result sets zero flag, single-cycle latency, then drains
    drive(1'b1, 32'h00000000, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    check("t1_valid", {63'd0, out_valid}, 64'd1);
    check("t1_result", {32'd0, out_result}, 64'd0);
    check("t1_zero_neg", {62'd0, out_zero, out_neg}, 64'd2);
    check("t1_rd_we", {58'd0, out_rd, out_we}, {58'd0, 5'd3, 1'b1});
    idle(1'b1);
    check("t1_drained", {63'd0, out_valid}, 64'd0);

    // 2: negative result with carry and overflow passed through
    drive(1'b1, 32'h80000000, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    check("t2_flags", {60'd0, out_zero, out_neg, out_carry, out_ovf}, 64'h7);
    idle(1'b1);
    check("t2_drained", {63'd0, out_valid}, 64'd0);

    // 3: fill to two, refuse a third, drain in order
    drive(1'b1, 32'hFFDF1F40, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
    check("t3_ready_after_one", {63'd0, in_ready}, 64'd1);
    drive(1'b1, 32'h80031F4F, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0);
    check("t3_full_ready", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    check("t3_hold_head", {32'd0, out_result}, {32'd0, 32'hFFDF1F40});
    idle(1'b1);
    check("t3_second", {32'd0, out_result}, {32'd0, 32'h80031F4F});
    check("t3_ready_after_pop", {63'd0, in_ready}, 64'd1);
    check("t3_second_we", {63'd0, out_we}, 64'd0);
    idle(1'b1);
    check("t3_empty", {63'd0, out_valid}, 64'd0);

    // 4: push and pop together at one entry replaces the head
    drive(1'b1, 32'h07FA07FD, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h12AFE847, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    check("t4_result", {32'd0, out_result}, {32'd0, 32'h12AFE847});
    check("t4_ready", {63'd0, in_ready}, 64'd1);
    idle(1'b1);
    check("t4_empty", {63'd0, out_valid}, 64'd0);

    // 5: flush at full discards everything, including a concurrent push
    drive(1'b1, 32'h11111111, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h22222222, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h33333333, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
    check("t5_flushed", {63'd0, out_valid}, 64'd0);
    check("t5_ready", {63'd0, in_ready}, 64'd1);
    check("t5_result_zero", {32'd0, out_result}, 64'd0);
    idle(1'b1);
    idle(1'b1);
    check("t5_no_leak", {63'd0, out_valid}, 64'd0);

    // 6: asynchronous reset mid-cycle at full, then a clean restart
    drive(1'b1, 32'hAAAA5555, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h5555AAAA, 1'b0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", {63'd0, out_valid}, 64'd0);
    check("t6_async_result", {32'd0, out_result}, 64'd0);
    check("t6_async_flags", {58'd0, out_rd, out_carry}, 64'd0);
    check("t6_async_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 32'h56FDA350, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
    check("t6_fresh", {32'd0, out_result}, {32'd0, 32'h56FDA350});
    check("t6_fresh_flags", {62'd0, out_zero, out_neg}, 64'd0);
    idle(1'b1);
    check("t6_single", {63'd0, out_valid}, 64'd0);
    idle(1'b1);
    check("t6_no_stale", {63'd0, out_valid}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
